// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - arbitrates ALU/load writeback onto one register-file write port
// and tracks outstanding destination registers in a pending scoreboard.
module writeback_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_WIDTH-1:0]      alu_rd,
  input  logic [DATA_WIDTH-1:0]      alu_data,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [ADDR_WIDTH-1:0]      load_rd,
  input  logic [DATA_WIDTH-1:0]      load_data,
  input  logic                       reserve_valid,
  input  logic [ADDR_WIDTH-1:0]      reserve_rd,
  output logic                       write_enable,
  output logic [ADDR_WIDTH-1:0]      register_write_select,
  output logic [DATA_WIDTH-1:0]      register_data_write,
  output logic [(2**ADDR_WIDTH)-1:0] pending,
  output logic [15:0]                stall_count
);

  localparam int         NREG  = 2**ADDR_WIDTH;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {PRI_LOAD, PRI_ALU} state_t;

  state_t                state, state_next;
  logic [3:0]            starve, starve_next;
  logic                  alu_xfer, load_xfer, refused;
  logic                  we_next;
  logic [ADDR_WIDTH-1:0] sel_next;
  logic [DATA_WIDTH-1:0] data_next;
  logic [NREG-1:0]       pending_next;
  logic [15:0]           stall_next;

  // Arbitration: the priority holder is always ready; the other side yields only on contention.
  always_comb begin
    alu_ready   = 1'b1;
    load_ready  = 1'b1;
    state_next  = state;
    starve_next = starve;
    if (state == PRI_LOAD) alu_ready  = ~load_valid;
    else                   load_ready = ~alu_valid;

    alu_xfer  = alu_valid & alu_ready;
    load_xfer = load_valid & load_ready;
    refused   = (alu_valid & ~alu_ready) | (load_valid & ~load_ready);

    if (alu_xfer)
      starve_next = 4'd0;
    else if (alu_valid && !alu_ready && starve != LIMIT)
      starve_next = starve + 4'd1;

    case (state)
      PRI_LOAD: if (starve_next == LIMIT) state_next = PRI_ALU;
      PRI_ALU:  if (alu_xfer)             state_next = PRI_LOAD;
      default:  state_next = PRI_LOAD;
    endcase
  end

  // Writes to x0 are accepted but suppressed; select/data hold as for an idle cycle.
  always_comb begin
    we_next   = 1'b0;
    sel_next  = register_write_select;
    data_next = register_data_write;
    if (alu_xfer && alu_rd != '0) begin
      we_next   = 1'b1;
      sel_next  = alu_rd;
      data_next = alu_data;
    end else if (load_xfer && load_rd != '0) begin
      we_next   = 1'b1;
      sel_next  = load_rd;
      data_next = load_data;
    end
  end

  // Clear applies first so a same-edge reserve of the written register wins.
  always_comb begin
    pending_next = pending;
    if (write_enable)  pending_next[register_write_select] = 1'b0;
    if (reserve_valid) pending_next[reserve_rd] = 1'b1;
    pending_next[0] = 1'b0;

    stall_next = stall_count;
    if (refused && stall_count != 16'hFFFF) stall_next = stall_count + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                 <= PRI_LOAD;
      starve                <= 4'd0;
      write_enable          <= 1'b0;
      register_write_select <= '0;
      register_data_write   <= '0;
      pending               <= '0;
      stall_count           <= 16'd0;
    end else begin
      state                 <= state_next;
      starve                <= starve_next;
      write_enable          <= we_next;
      register_write_select <= sel_next;
      register_data_write   <= data_next;
      pending               <= pending_next;
      stall_count           <= stall_next;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - table-driven directed bench for writeback_arbiter
module tb_writeback_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0, load_valid = 1'b0, reserve_valid = 1'b0;
  logic        alu_ready, load_ready;
  logic [4:0]  alu_rd = '0, load_rd = '0, reserve_rd = '0;
  logic [31:0] alu_data = '0, load_data = '0;
  logic        write_enable;
  logic [4:0]  register_write_select;
  logic [31:0] register_data_write;
  logic [31:0] pending;
  logic [15:0] stall_count;

  int n_cmp  = 0;
  int n_fail = 0;

  writeback_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .STARVE_LIMIT(3)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .load_valid(load_valid), .load_ready(load_ready), .load_rd(load_rd), .load_data(load_data),
    .reserve_valid(reserve_valid), .reserve_rd(reserve_rd),
    .write_enable(write_enable), .register_write_select(register_write_select),
    .register_data_write(register_data_write), .pending(pending), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] adat;
    logic        lv;  logic [4:0] lrd; logic [31:0] ldat;
    logic        rv;  logic [4:0] rrd;
    logic        e_ar; logic e_lr; logic e_we;
    logic [4:0]  e_sel; logic [31:0] e_data; logic [31:0] e_pend; logic [15:0] e_stall;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic rv, input logic [4:0] rrd);
    alu_valid = av;  alu_rd = ard;  alu_data = adat;
    load_valid = lv; load_rd = lrd; load_data = ldat;
    reserve_valid = rv; reserve_rd = rrd;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_we"},    {31'b0, write_enable}, 32'h0);
    check({tag, "_sel"},   {27'b0, register_write_select}, 32'h0);
    check({tag, "_data"},  register_data_write, 32'h0);
    check({tag, "_pend"},  pending, 32'h0);
    check({tag, "_stall"}, {16'b0, stall_count}, 32'h0);
  endtask

  initial begin
    // av ard adat        lv lrd ldat          rv rrd | ar lr we sel data          pend         stall
    vecs[0]  = '{1'b0,5'd0,32'h0,      1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0, 1'b0,1'b1,1'b1,5'd5,32'hDEADBEEF,32'h0,       16'd0};
    vecs[1]  = '{1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,        1'b1,5'd7, 1'b1,1'b1,1'b0,5'd5,32'hDEADBEEF,32'h80,      16'd0};
    vecs[2]  = '{1'b1,5'd7,32'h1234,   1'b0,5'd0,32'h0,        1'b0,5'd0, 1'b1,1'b1,1'b1,5'd7,32'h1234,    32'h80,      16'd0};
    vecs[3]  = '{1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,        1'b0,5'd0, 1'b1,1'b1,1'b0,5'd7,32'h1234,    32'h0,       16'd0};
    vecs[4]  = '{1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,        1'b1,5'd7, 1'b1,1'b1,1'b0,5'd7,32'h1234,    32'h80,      16'd0};
    vecs[5]  = '{1'b1,5'd7,32'h55,     1'b0,5'd0,32'h0,        1'b0,5'd0, 1'b1,1'b1,1'b1,5'd7,32'h55,      32'h80,      16'd0};
    vecs[6]  = '{1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,        1'b1,5'd7, 1'b1,1'b1,1'b0,5'd7,32'h55,      32'h80,      16'd0};
    vecs[7]  = '{1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,        1'b1,5'd0, 1'b1,1'b1,1'b0,5'd7,32'h55,      32'h80,      16'd0};
    vecs[8]  = '{1'b1,5'd0,32'h1,      1'b0,5'd0,32'h0,        1'b0,5'd0, 1'b1,1'b1,1'b0,5'd7,32'h55,      32'h80,      16'd0};
    vecs[9]  = '{1'b0,5'd0,32'h0,      1'b1,5'd3,32'hA5A5,     1'b1,5'd3, 1'b0,1'b1,1'b1,5'd3,32'hA5A5,    32'h88,      16'd0};
    vecs[10] = '{1'b0,5'd0,32'h0,      1'b0,5'd0,32'h0,        1'b0,5'd0, 1'b1,1'b1,1'b0,5'd3,32'hA5A5,    32'h80,      16'd0};

    #1;
    check_reset_state("reset_init");
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      drive(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].lv, vecs[i].lrd, vecs[i].ldat,
            vecs[i].rv, vecs[i].rrd);
      #1;
      check($sformatf("v%0d_alu_ready", i),  {31'b0, alu_ready},  {31'b0, vecs[i].e_ar});
      check($sformatf("v%0d_load_ready", i), {31'b0, load_ready}, {31'b0, vecs[i].e_lr});
      @(posedge clock);
      #1;
      check($sformatf("v%0d_we", i),    {31'b0, write_enable}, {31'b0, vecs[i].e_we});
      check($sformatf("v%0d_sel", i),   {27'b0, register_write_select}, {27'b0, vecs[i].e_sel});
      check($sformatf("v%0d_data", i),  register_data_write, vecs[i].e_data);
      check($sformatf("v%0d_pend", i),  pending, vecs[i].e_pend);
      check($sformatf("v%0d_stall", i), {16'b0, stall_count}, {16'b0, vecs[i].e_stall});
    end

    // Starvation: both requesters valid every cycle from a fresh reset.
    @(negedge clock);
    idle();
    reset = 1'b1;
    #1;
    check_reset_state("reset_again");
    @(negedge clock);
    reset = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0);
      #1;
      check($sformatf("starve_c%0d_alu_ready", c),  {31'b0, alu_ready},  (c == 4) ? 32'h1 : 32'h0);
      check($sformatf("starve_c%0d_load_ready", c), {31'b0, load_ready}, (c == 4) ? 32'h0 : 32'h1);
      check($sformatf("starve_c%0d_stall_pre", c),  {16'b0, stall_count}, 32'(c - 1));
      @(posedge clock);
      #1;
      check($sformatf("starve_c%0d_we", c),  {31'b0, write_enable}, 32'h1);
      check($sformatf("starve_c%0d_sel", c), {27'b0, register_write_select}, (c == 4) ? 32'd1 : 32'd2);
      check($sformatf("starve_c%0d_data", c), register_data_write, (c == 4) ? 32'h11 : 32'h22);
    end

    // Reset asserted while a write is on the port and x2 is pending.
    @(negedge clock);
    drive(1'b1, 5'd2, 32'h77, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2);
    @(posedge clock);
    #1;
    check("midwrite_we",   {31'b0, write_enable}, 32'h1);
    check("midwrite_pend", pending, 32'h4);
    check("midwrite_stall_nonzero", {31'b0, (stall_count != 16'd0)}, 32'h1);
    #1;
    idle();
    reset = 1'b1;
    #1;
    check_reset_state("reset_mid");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("post_reset_we", {31'b0, write_enable}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
